// File: rtl/arm_dbg_pkg.sv
// arm_dbg_pkg: shared state encoding, status-window offsets and signature for the store checker
package arm_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [31:0] OFS_STATE  = 32'd0;
    localparam logic [31:0] OFS_STORES = 32'd4;
    localparam logic [31:0] OFS_CYCLES = 32'd8;
    localparam logic [31:0] OFS_SIG    = 32'd12;

    localparam logic [31:0] SIGNATURE = 32'h00C0FFEE;

endpackage

// File: rtl/store_matcher.sv
// store_matcher: compares one bus transfer against a single expected {address, data} entry
//   adr, dat  : observed address / write data
//   adr_hit   : address matches the entry
//   full_hit  : address and data both match
module store_matcher #(
    parameter logic [31:0] EXP_ADR = 32'h0,
    parameter logic [31:0] EXP_DAT = 32'h0
) (
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic        adr_hit,
    output logic        full_hit
);

    assign adr_hit  = adr == EXP_ADR;
    assign full_hit = adr_hit && dat == EXP_DAT;

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: watches data-memory stores for an ordered pair of expected writes, with timeout
//   clk, reset            : processor clock, synchronous active-high reset
//   start                 : checking runs while high
//   Write_Enable, DataAdr, WriteData : processor store bus
//   StatData, StatHit     : read-only status window, muxed by the top over datamem ReadData
//   stop, pass, fail      : verdict and processor clock-gate request
//   LED_pass, LED_fail, LED_prog : active-low board LEDs
module mem_write_checker
    import arm_dbg_pkg::*;
#(
    parameter logic [31:0] EXP_ADR0  = 32'h00000014,
    parameter logic [31:0] EXP_DAT0  = 32'h00000007,
    parameter logic [31:0] EXP_ADR1  = 32'h0000001A,
    parameter logic [31:0] EXP_DAT1  = 32'h00000007,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] STAT_BASE = 32'h000000F0,
    parameter int          BLINK_W   = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        Write_Enable,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] StatData,
    output logic        StatHit,
    output logic        stop,
    output logic        pass,
    output logic        fail,
    output logic        LED_pass,
    output logic        LED_fail,
    output logic [1:0]  LED_prog
);

    state_t             state, state_n;
    logic [1:0]         hits, hits_n;
    logic [15:0]        store_cnt;
    logic [31:0]        cyc_cnt;
    logic [BLINK_W-1:0] blink;
    logic               adr0, full0, adr1, full1;
    logic               valid, bad;
    logic [31:0]        ofs;

    store_matcher #(.EXP_ADR(EXP_ADR0), .EXP_DAT(EXP_DAT0)) u_m0 (
        .adr(DataAdr), .dat(WriteData), .adr_hit(adr0), .full_hit(full0)
    );
    store_matcher #(.EXP_ADR(EXP_ADR1), .EXP_DAT(EXP_DAT1)) u_m1 (
        .adr(DataAdr), .dat(WriteData), .adr_hit(adr1), .full_hit(full1)
    );

    // Stores into the status window are neither checked nor counted
    assign valid = Write_Enable && !StatHit;
    assign bad   = (valid && ((adr0 && !full0) || (adr1 && !full1) || (full1 && !hits[0])))
                || cyc_cnt == 32'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        hits_n  = hits;
        unique case (state)
            IDLE: state_n = start ? RUN : IDLE;
            RUN: begin
                if (!start) begin
                    state_n = IDLE;
                    hits_n  = 2'b00;
                end else if (valid && full1 && hits[0]) begin
                    // PASS deliberately outranks a coincident timeout
                    state_n = PASS;
                    hits_n  = 2'b11;
                end else if (bad) begin
                    state_n = FAIL;
                end else if (valid && full0) begin
                    hits_n[0] = 1'b1;
                end
            end
            default: begin
                state_n = start ? state : IDLE;
                hits_n  = start ? hits : 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hits      <= 2'b00;
            store_cnt <= 16'd0;
            cyc_cnt   <= 32'd0;
            blink     <= '0;
        end else begin
            state     <= state_n;
            hits      <= hits_n;
            cyc_cnt   <= state_n == IDLE ? 32'd0 : state == RUN ? cyc_cnt + 32'd1 : cyc_cnt;
            store_cnt <= state_n == IDLE ? 16'd0
                       : (state == RUN && valid && store_cnt != 16'hFFFF) ? store_cnt + 16'd1
                       : store_cnt;
            blink     <= state == FAIL ? blink + 1'b1 : '0;
        end
    end

    assign pass = state == PASS;
    assign fail = state == FAIL;
    assign stop = pass || fail;

    assign LED_pass = ~pass;
    assign LED_fail = ~(fail & blink[BLINK_W-1]);
    assign LED_prog = ~hits;

    // Offset wraps for addresses below the base, so one compare covers both sides
    assign ofs      = DataAdr - STAT_BASE;
    assign StatHit  = ofs < 32'd16 && ofs[1:0] == 2'b00;
    assign StatData = !StatHit            ? 32'd0
                    : ofs == OFS_STATE    ? {28'd0, state, hits}
                    : ofs == OFS_STORES   ? {16'd0, store_cnt}
                    : ofs == OFS_CYCLES   ? cyc_cnt
                    : SIGNATURE;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed and randomized self-checking bench for mem_write_checker
module tb_mem_write_checker;

    localparam logic [31:0] A0 = 32'h14, D0 = 32'h7, A1 = 32'h1A, D1 = 32'h7;
    localparam logic [31:0] SB = 32'hF0;
    localparam int TMO = 1024;
    localparam int BW  = 4;

    logic        clk = 0, reset = 1, start = 0, Write_Enable = 0;
    logic [31:0] DataAdr = 0, WriteData = 0;
    logic [31:0] StatData;
    logic        StatHit, stop, pass, fail, LED_pass, LED_fail;
    logic [1:0]  LED_prog;

    int n_checks = 0, n_fail = 0;

    // reference model: verdict 0=idle 1=running 2=passed 3=failed
    int          m_phase = 0, m_stores = 0, m_blink = 0;
    longint      m_cycles = 0;
    bit          seen0 = 0, seen1 = 0;
    int          lf_low = 0, lf_high = 0;

    mem_write_checker #(.BLINK_W(BW)) dut (
        .clk(clk), .reset(reset), .start(start), .Write_Enable(Write_Enable),
        .DataAdr(DataAdr), .WriteData(WriteData), .StatData(StatData), .StatHit(StatHit),
        .stop(stop), .pass(pass), .fail(fail), .LED_pass(LED_pass), .LED_fail(LED_fail),
        .LED_prog(LED_prog)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_phase = 0; m_stores = 0; m_cycles = 0; seen0 = 0; seen1 = 0;
    endtask

    task automatic model(input bit we, input logic [31:0] adr, input logic [31:0] dat);
        bit good1, err, tmo;
        m_blink = (m_phase == 3) ? m_blink + 1 : 0;
        if (reset) begin
            clear_model();
            m_blink = 0;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!start) clear_model();
            else begin
                tmo   = (m_cycles == TMO - 1);
                good1 = we && adr == A1 && dat == D1 && seen0;
                err   = we && ((adr == A0 && dat != D0) || (adr == A1 && (dat != D1 || !seen0)));
                m_cycles++;
                if (we && m_stores < 65535) m_stores++;
                if (good1) begin seen1 = 1; m_phase = 2; end
                else if (err || tmo) m_phase = 3;
                else if (we && adr == A0) seen0 = 1;
            end
        end else if (!start) clear_model();
    endtask

    task automatic rd(input logic [31:0] ofs, input logic [31:0] exp, input string tag);
        DataAdr = SB + ofs; Write_Enable = 0;
        #1;
        chk({tag, "_hit"}, 32'(StatHit), 32'd1);
        chk(tag, StatData, exp);
    endtask

    task automatic cyc(input bit we, input logic [31:0] adr, input logic [31:0] dat);
        Write_Enable = we; DataAdr = adr; WriteData = dat;
        model(we, adr, dat);
        @(posedge clk); #1;
        Write_Enable = 0;
        chk("pass", 32'(pass), 32'(m_phase == 2));
        chk("fail", 32'(fail), 32'(m_phase == 3));
        chk("stop", 32'(stop), 32'(m_phase >= 2));
        chk("led_pass", 32'(LED_pass), 32'(m_phase != 2));
        chk("led_prog", 32'(LED_prog), 32'(~{seen1, seen0} & 2'b11));
        chk("led_fail", 32'(LED_fail), 32'(!(m_phase == 3 && m_blink[BW-1])));
        if (m_phase == 3) begin
            if (LED_fail) lf_high++; else lf_low++;
        end
        rd(0, 32'(m_phase * 4 + seen1 * 2 + seen0), "stat0");
        rd(4, 32'(m_stores), "stat4");
        rd(8, 32'(m_cycles), "stat8");
    endtask

    function automatic logic [31:0] other_adr();
        return 32'h100 + 4 * $urandom_range(0, 63);
    endfunction

    initial begin
        // reset state
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset_led_fail", 32'(LED_fail), 32'd1);
        reset = 0;
        // ordered pair passes
        start = 1;
        cyc(0, 0, 0);
        cyc(1, A0, D0);
        cyc(1, A1, D1);
        cyc(0, 0, 0);
        chk("pass_sticky", 32'(pass), 32'd1);
        start = 0;
        cyc(0, 0, 0);
        // order violation, then LED_fail blinking
        start = 1;
        cyc(0, 0, 0);
        cyc(1, A1, D1);
        lf_low = 0; lf_high = 0;
        for (int i = 0; i < 40; i++) cyc(0, 0, 0);
        chk("blink_both", 32'(lf_low > 0 && lf_high > 0), 32'd1);
        start = 0;
        cyc(0, 0, 0);
        // wrong data to first address
        start = 1;
        cyc(0, 0, 0);
        cyc(1, A0, 32'h5);
        rd(0, 32'hC, "wrong_data_stat0");
        start = 0;
        cyc(0, 0, 0);
        // timeout
        start = 1;
        cyc(0, 0, 0);
        for (int i = 0; i < TMO + 3; i++) cyc(0, 0, 0);
        chk("timeout_fail", 32'(fail), 32'd1);
        start = 0;
        cyc(0, 0, 0);
        rd(8, 0, "cleared_cyc");
        // unrelated stores counted, signature, out-of-window reads
        start = 1;
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, other_adr(), $urandom);
        cyc(1, A0, D0);
        for (int i = 0; i < 2; i++) cyc(1, other_adr(), $urandom);
        cyc(1, A1, D1);
        rd(4, 7, "seven_stores");
        rd(12, 32'h00C0FFEE, "signature");
        DataAdr = SB + 16; #1;
        chk("oow_hit", 32'(StatHit), 32'd0);
        chk("oow_data", StatData, 32'd0);
        DataAdr = SB + 2; #1;
        chk("unaligned_hit", 32'(StatHit), 32'd0);
        start = 0;
        cyc(0, 0, 0);
        // reset mid-run, then a clean pass
        start = 1;
        cyc(0, 0, 0);
        cyc(1, A0, D0);
        reset = 1;
        cyc(0, 0, 0);
        reset = 0;
        cyc(0, 0, 0);
        cyc(1, A0, D0);
        cyc(1, A1, D1);
        start = 0;
        cyc(0, 0, 0);
        // randomized episodes
        for (int e = 0; e < 40; e++) begin
            start = 1;
            for (int i = 0; i < 25; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 9 && $urandom_range(0, 3) == 0) start = 0;
                case (r)
                    0, 1:    cyc(1, A0, D0);
                    2:       cyc(1, A1, D1);
                    3:       cyc(1, A0, $urandom_range(0, 15));
                    4:       cyc(1, A1, $urandom_range(0, 15));
                    5, 6:    cyc(1, other_adr(), $urandom);
                    default: cyc(0, other_adr(), $urandom);
                endcase
                start = 1;
            end
            start = 0;
            cyc(0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
